// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through one full-subtractor cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bout;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_fs (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Handshake flags follow the next state so they are flops, not decode of inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == ST_IDLE);
      r_out_valid <= (w_state_next == ST_DONE);
    end
  end

  // Operand load, serial shift and borrow chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_diff  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_ovf   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_br   <= w_bout;
      if (w_last) begin
        // w_d is the result MSB on the final step
        r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_br;
  assign ovf       = r_ovf;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_RAND = 1000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, borrow, diff} from plain integer arithmetic
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int ux, uy, sx, sy, sr;
    logic [WIDTH-1:0] d;
    logic br, ov;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    sr = sx - sy;
    d  = WIDTH'((ux - uy + 256) % 256);
    br = (ux < uy);
    ov = (sr > 127) || (sr < -128);
    return {ov, br, d};
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input int stall);
    logic [WIDTH+1:0] exp;
    int lat;
    bit found;
    exp = model(op_a, op_b);
    @(negedge clk);
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        found = 1'b1;
      end
    end
    check("latency", 32'(lat), 32'(WIDTH));
    @(negedge clk);
    check("diff", 32'(diff), 32'(exp[WIDTH-1:0]));
    check("borrow", 32'(borrow), 32'(exp[WIDTH]));
    check("ovf", 32'(ovf), 32'(exp[WIDTH+1]));
    for (int s = 0; s < stall; s++) begin
      in_valid = s[0];
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_diff", 32'(diff), 32'(exp[WIDTH-1:0]));
      check("stall_flags", 32'({ovf, borrow}), 32'(exp[WIDTH+1:WIDTH]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("xfer_valid_low", 32'(out_valid), 32'd0);
    check("xfer_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] exp;
    int n_acc, n_res, cyc, last_acc;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({ovf, borrow, diff}), 32'd0);
    rst = 1'b0;

    run_op(8'h5A, 8'h3C, 0);
    run_op(8'h00, 8'h01, 0);
    run_op(8'h80, 8'h01, 5);
    run_op(8'h7F, 8'hFF, 2);

    // Async reset in the middle of RUN, with the counter at 3
    @(negedge clk);
    a = 8'hC3;
    b = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    check("midrun_outputs", 32'({ovf, borrow, diff}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h10, 8'h10, 0);

    // Back-to-back stream with both handshakes held high
    n_acc = 0;
    n_res = 0;
    cyc = 0;
    last_acc = -1;
    out_ready = 1'b1;
    while (n_res < int'(N_RAND) && cyc < 15000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          check("stream_result", 32'({ovf, borrow, diff}), 32'(exp));
        end
        n_res++;
      end
      in_valid = (n_acc < int'(N_RAND));
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        if (last_acc >= 0) check("accept_period", 32'(cyc - last_acc), 32'(WIDTH + 2));
        last_acc = cyc;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count", 32'(n_res), 32'(N_RAND));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
